shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
- Two-port Avalon-MM arbiter sharing one on-chip shared-memory slave between two masters.
- Port s0 is fed by the HPS shared-memory bridge master (burstcount 1, 18-bit address, 32-bit data).
- Port s1 is fed by an FPGA-side requester (Nios II data master or DMA).
- Round-robin grant, one command per grant, pipelined reads tracked by a pending-ID FIFO so readdata returns to the correct requester.

Parameters:
- ADDR_W, 18, word-address width on all ports
- DATA_W, 32, data width; byteenable width = DATA_W/8
- MAX_PEND, 4, maximum outstanding reads (pending-ID FIFO depth, power of 2)

Ports:
- clk_clk  in  1  single clock for all logic
- reset_reset_n  in  1  asynchronous active-low reset
- sN_address  in  ADDR_W  requester N address (N = 0, 1; applies to every sN_ line)
- sN_read  in  1  requester N read request
- sN_write  in  1  requester N write request
- sN_writedata  in  DATA_W  requester N write data
- sN_byteenable  in  DATA_W/8  requester N byte enables
- sN_waitrequest  out  1  stall to requester N
- sN_readdata  out  DATA_W  read data (broadcast)
- sN_readdatavalid  out  1  read data valid for requester N
- m_address  out  ADDR_W  to shared memory
- m_read  out  1  to shared memory
- m_write  out  1  to shared memory
- m_writedata  out  DATA_W  to shared memory
- m_byteenable  out  DATA_W/8  to shared memory
- m_waitrequest  in  1  from shared memory
- m_readdata  in  DATA_W  from shared memory
- m_readdatavalid  in  1  from shared memory
- orphan_err  out  1  sticky: readdatavalid arrived with no read pending

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; m_read/m_write = 0; m_address/m_writedata/m_byteenable = 0; s0/s1_waitrequest = 1; readdatavalid = 0; pending FIFO empty; rr_last = 1, so s0 wins the first tie; orphan_err = 0.
- States: IDLE, XFER.
- IDLE: requester N is eligible if sN_write, or sN_read with the FIFO not full.
  - One eligible requester: grant it.
  - Both eligible: grant the one not equal to rr_last.
  - On grant: latch owner and go to XFER next cycle.
  - Both waitrequest outputs stay 1 in IDLE.
- XFER: m_* driven combinationally from the owner's sN_* lines.
  - Owner's waitrequest = m_waitrequest; non-owner's waitrequest = 1.
  - When m_waitrequest = 0 and (m_read or m_write): command accepted. On a read, push owner ID into the FIFO. Set rr_last = owner; return to IDLE.
  - If the owner drops read/write while in XFER (protocol violation): return to IDLE, nothing issued.
- Latency:
  - Minimum 2 cycles from request to acceptance (1 arbitration cycle + 1 XFER cycle with m_waitrequest low).
  - Back-to-back throughput: 1 command per 2 cycles.
- Read return:
  - sN_readdatavalid = m_readdatavalid AND FIFO non-empty AND head ID == N, combinational.
  - Pop the FIFO on every m_readdatavalid while non-empty.
  - readdata = m_readdata on both ports.
- Simultaneous push (accept) and pop (return) in one cycle: occupancy unchanged; a push to an empty FIFO is not visible to the same-cycle pop.
- FIFO full (MAX_PEND reads outstanding): reads are not granted; writes still granted. Writes never enter the FIFO.
- m_readdatavalid with the FIFO empty: data dropped, orphan_err set (cleared only by reset). This covers responses still in flight across a reset.
- Reset mid-XFER: m_read/m_write drop immediately (async); the pending transaction is abandoned.
- Width rules: FIFO pointers are log2(MAX_PEND) bits with a separate count of log2(MAX_PEND)+1 bits; pointers wrap naturally.

Test Plan:
- Single read from s0 at address 0x00010, memory returns 0xCAFEF00D 2 cycles after acceptance -> m_read high exactly 1 cycle; s0_readdatavalid pulses once with 0xCAFEF00D; s1_readdatavalid stays 0.
- s0 and s1 both hold a write every cycle for 8 commands -> grants alternate s0,s1,s0,s1…; each completes 4 writes; s0 goes first after reset.
- s1 issues 5 reads with readdatavalid held off (MAX_PEND=4) -> 4 accepted; 5th held with s1_waitrequest = 1 until the first readdatavalid, then accepted.
- Interleaved s0 read (addr 0x3), s1 read (addr 0x7); memory returns 0x3, 0x7 in order -> s0 receives 0x3, s1 receives 0x7.
- m_waitrequest held high 5 cycles during an s1 write of 0x12345678 with byteenable 0x6 -> m_* lines stable for all 6 cycles; s0 sees waitrequest = 1 throughout; write accepted once.
- Assert reset_reset_n low mid-XFER, then inject m_readdatavalid after release -> m_read = 0 immediately; no sN_readdatavalid; orphan_err = 1.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// Two-master round-robin Avalon-MM arbiter in front of one shared-memory slave.
// Reads are pipelined; a small ID FIFO routes each readdatavalid back to its requester.
module shared_mem_arbiter #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 32,
    parameter int MAX_PEND = 4
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [ADDR_W-1:0]     s0_address,
    input  logic                  s0_read,
    input  logic                  s0_write,
    input  logic [DATA_W-1:0]     s0_writedata,
    input  logic [DATA_W/8-1:0]   s0_byteenable,
    output logic                  s0_waitrequest,
    output logic [DATA_W-1:0]     s0_readdata,
    output logic                  s0_readdatavalid,
    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W-1:0]     s1_writedata,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    output logic                  s1_waitrequest,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic [ADDR_W-1:0]     m_address,
    output logic                  m_read,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata,
    output logic [DATA_W/8-1:0]   m_byteenable,
    input  logic                  m_waitrequest,
    input  logic [DATA_W-1:0]     m_readdata,
    input  logic                  m_readdatavalid,
    output logic                  orphan_err
);
    localparam int PW = $clog2(MAX_PEND);

    typedef enum logic {IDLE, XFER} state_t;

    logic [1:0] rst_sync_q;
    logic       rst_n;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           rr_last_q, rr_last_d;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PW:0]    cnt_q, cnt_d;
    logic           fifo_q [MAX_PEND];
    logic           orphan_q;

    logic fifo_full, fifo_empty, elig0, elig1, xfer, push, pop, head_id;
    logic own_read, own_write;

    // Assert asynchronously, release synchronously to clk_clk.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) rst_sync_q <= '0;
        else                rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign fifo_full  = (cnt_q == (PW+1)'(MAX_PEND));
    assign fifo_empty = (cnt_q == '0);
    assign elig0      = s0_write | (s0_read & ~fifo_full);
    assign elig1      = s1_write | (s1_read & ~fifo_full);
    assign xfer       = (state_q == XFER);
    assign own_read   = owner_q ? s1_read  : s0_read;
    assign own_write  = owner_q ? s1_write : s0_write;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    state_d = XFER;
                    owner_d = (elig0 & elig1) ? ~rr_last_q : elig1;
                end
            end
            XFER: begin
                if (!(own_read | own_write)) begin
                    state_d = IDLE;
                end else if (!m_waitrequest) begin
                    state_d   = IDLE;
                    rr_last_d = owner_q;
                    push      = own_read;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_read       = xfer & own_read;
    assign m_write      = xfer & own_write;
    assign m_address    = xfer ? (owner_q ? s1_address    : s0_address)    : '0;
    assign m_writedata  = xfer ? (owner_q ? s1_writedata  : s0_writedata)  : '0;
    assign m_byteenable = xfer ? (owner_q ? s1_byteenable : s0_byteenable) : '0;

    assign s0_waitrequest = ~(xfer & ~owner_q) | m_waitrequest;
    assign s1_waitrequest = ~(xfer &  owner_q) | m_waitrequest;

    // Pop uses the registered count, so a push into an empty FIFO is not seen this cycle.
    assign pop              = m_readdatavalid & ~fifo_empty;
    assign head_id          = fifo_q[rd_ptr_q];
    assign s0_readdatavalid = pop & ~head_id;
    assign s1_readdatavalid = pop &  head_id;
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;
    assign orphan_err       = orphan_q;

    always_comb begin
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            orphan_q  <= 1'b0;
            for (int i = 0; i < MAX_PEND; i++) fifo_q[i] <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            cnt_q     <= cnt_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= owner_q;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (m_readdatavalid && fifo_empty) orphan_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: memory slave model, per-port scoreboards, directed and random traffic.
module tb_shared_mem_arbiter;
    localparam int ADDR_W = 18, DATA_W = 32, BE_W = 4, MAX_PEND = 4;

    logic              clk_clk = 1'b0, reset_reset_n = 1'b0;
    logic [ADDR_W-1:0] s0_address = '0, s1_address = '0;
    logic              s0_read = 1'b0, s0_write = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
    logic [DATA_W-1:0] s0_writedata = '0, s1_writedata = '0;
    logic [BE_W-1:0]   s0_byteenable = '0, s1_byteenable = '0;
    logic              s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
    logic [DATA_W-1:0] s0_readdata, s1_readdata;
    logic [ADDR_W-1:0] m_address;
    logic              m_read, m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [BE_W-1:0]   m_byteenable;
    logic              m_waitrequest = 1'b1, m_readdatavalid = 1'b0;
    logic [DATA_W-1:0] m_readdata = '0;
    logic              orphan_err;

    shared_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .orphan_err(orphan_err)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc = cyc + 1;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Memory contents: a fixed function of the address, so reads need no write history.
    function automatic logic [31:0] mem_val(input logic [ADDR_W-1:0] a);
        return (a == 18'h00010) ? 32'hCAFEF00D : 32'(a);
    endfunction

    typedef struct { int due; logic [31:0] data; } rsp_t;
    typedef struct { logic [ADDR_W-1:0] a; logic [31:0] d; logic [3:0] be; } wr_t;

    rsp_t        rsp_q[$];
    wr_t         exp_wr0[$], exp_wr1[$];
    logic [31:0] exp_rd0[$], exp_rd1[$];
    bit          wr_port_log[$];

    int wait_mode = 1;          // 0 random, 1 forced high, 2 forced low
    int lat_min = 2, lat_max = 2;
    bit hold_rdv = 1'b0;
    int inject_req = 0, inject_done = 0;
    int n_rd_acc = 0, n_wr_acc = 0, n_mread_cyc = 0, n_mwrite_cyc = 0;
    int n_rdv0 = 0, n_rdv1 = 0;

    // Memory slave: sample commands mid-cycle, update its outputs just after the edge.
    always begin
        @(negedge clk_clk);
        if (!reset_reset_n) begin
            rsp_q.delete();
        end else begin
            if (m_read)  n_mread_cyc++;
            if (m_write) n_mwrite_cyc++;
            if (m_read && !m_waitrequest) begin
                rsp_t r;
                n_rd_acc++;
                r.due  = cyc + 1 + int'($urandom_range(lat_max, lat_min));
                r.data = mem_val(m_address);
                rsp_q.push_back(r);
            end
            if (m_write && !m_waitrequest) begin
                wr_t e;
                bit  p;
                n_wr_acc++;
                p = m_address[ADDR_W-1];
                wr_port_log.push_back(p);
                if ((p ? exp_wr1.size() : exp_wr0.size()) == 0) begin
                    fail($sformatf("unexpected write addr 0x%0h", m_address));
                end else begin
                    e = p ? exp_wr1.pop_front() : exp_wr0.pop_front();
                    chk("write addr", 64'(m_address), 64'(e.a));
                    chk("write data", 64'(m_writedata), 64'(e.d));
                    chk("write be", 64'(m_byteenable), 64'(e.be));
                end
            end
        end
        @(posedge clk_clk);
        #1;
        m_waitrequest   = (wait_mode == 1) ? 1'b1 : (wait_mode == 2) ? 1'b0 : ($urandom % 3 == 0);
        m_readdatavalid = 1'b0;
        m_readdata      = $urandom;
        if (inject_req != inject_done) begin
            inject_done++;
            m_readdatavalid = 1'b1;
            m_readdata      = 32'hDEADBEEF;
        end else if (!hold_rdv && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            rsp_t r;
            r = rsp_q.pop_front();
            m_readdatavalid = 1'b1;
            m_readdata      = r.data;
        end
    end

    // Read-return monitor: each port's data must come back in issue order.
    always @(negedge clk_clk) begin
        if (reset_reset_n) begin
            if (s0_readdatavalid) begin
                n_rdv0++;
                if (exp_rd0.size() == 0) fail("unexpected s0_readdatavalid");
                else chk("s0 readdata", 64'(s0_readdata), 64'(exp_rd0.pop_front()));
            end
            if (s1_readdatavalid) begin
                n_rdv1++;
                if (exp_rd1.size() == 0) fail("unexpected s1_readdatavalid");
                else chk("s1 readdata", 64'(s1_readdata), 64'(exp_rd1.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic drive(input int p, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (p == 0) begin
            s0_address = a; s0_writedata = d; s0_byteenable = be; s0_read = rd; s0_write = wr;
        end else begin
            s1_address = a; s1_writedata = d; s1_byteenable = be; s1_read = rd; s1_write = wr;
        end
    endtask

    // One Avalon command: expectation is queued at issue, request held until accepted.
    task automatic m_op(input int p, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        int  n = 0;
        wr_t e;
        if (wr) begin
            e.a = a; e.d = d; e.be = be;
            if (p == 0) exp_wr0.push_back(e); else exp_wr1.push_back(e);
        end else begin
            if (p == 0) exp_rd0.push_back(mem_val(a)); else exp_rd1.push_back(mem_val(a));
        end
        drive(p, !wr, wr, a, d, be);
        do begin
            @(negedge clk_clk);
            n++;
        end while ((p == 0 ? s0_waitrequest : s1_waitrequest) && n < 300);
        if (n >= 300) fail($sformatf("s%0d command timeout addr 0x%0h", p, a));
        @(posedge clk_clk);
        #1;
        drive(p, 1'b0, 1'b0, a, d, be);
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        step(2);
        chk("reset m_read", 64'(m_read), 64'd0);
        chk("reset m_write", 64'(m_write), 64'd0);
        chk("reset m_address", 64'(m_address), 64'd0);
        chk("reset m_writedata", 64'(m_writedata), 64'd0);
        chk("reset m_byteenable", 64'(m_byteenable), 64'd0);
        chk("reset s0_waitrequest", 64'(s0_waitrequest), 64'd1);
        chk("reset s1_waitrequest", 64'(s1_waitrequest), 64'd1);
        chk("reset readdatavalid", 64'({s0_readdatavalid, s1_readdatavalid}), 64'd0);
        chk("reset orphan_err", 64'(orphan_err), 64'd0);
        reset_reset_n = 1'b1;
        step(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, b_acc, b_mr, b_mw, b_r0, b_r1, n;
        bit ok;

        do_reset();

        // Both masters hold writes: grants alternate starting with s0.
        wait_mode = 2;
        base = wr_port_log.size();
        fork
            for (int i = 0; i < 4; i++) m_op(0, 1'b1, {1'b0, 17'(i)}, 32'h0A000000 + i, 4'hF);
            for (int i = 0; i < 4; i++) m_op(1, 1'b1, {1'b1, 17'(i)}, 32'h0B000000 + i, 4'hF);
        join
        step(2);
        chk("rr write count", 64'(wr_port_log.size() - base), 64'd8);
        for (int i = 0; i < 8 && base + i < wr_port_log.size(); i++)
            chk($sformatf("rr grant %0d", i), 64'(wr_port_log[base + i]), 64'(i % 2));

        // Single s0 read, data two cycles after acceptance.
        b_mr = n_mread_cyc; b_r0 = n_rdv0; b_r1 = n_rdv1;
        m_op(0, 1'b0, 18'h00010, '0, 4'hF);
        step(6);
        chk("single read m_read cycles", 64'(n_mread_cyc - b_mr), 64'd1);
        chk("single read s0 rdv pulses", 64'(n_rdv0 - b_r0), 64'd1);
        chk("single read s1 rdv pulses", 64'(n_rdv1 - b_r1), 64'd0);

        // Interleaved reads from both ports route back correctly.
        b_r0 = n_rdv0; b_r1 = n_rdv1;
        fork
            m_op(0, 1'b0, 18'h3, '0, 4'hF);
            m_op(1, 1'b0, 18'h7, '0, 4'hF);
        join
        step(8);
        chk("interleave s0 rdv", 64'(n_rdv0 - b_r0), 64'd1);
        chk("interleave s1 rdv", 64'(n_rdv1 - b_r1), 64'd1);

        // Fill the pending FIFO; the fifth read waits for the first return.
        hold_rdv = 1'b1;
        b_acc = n_rd_acc; b_r1 = n_rdv1;
        for (int i = 0; i < 4; i++) m_op(1, 1'b0, 18'h100 + 18'(i), '0, 4'hF);
        chk("fifo fill accepted", 64'(n_rd_acc - b_acc), 64'd4);
        fork
            m_op(1, 1'b0, 18'h104, '0, 4'hF);
            begin
                ok = 1'b1;
                repeat (6) begin
                    @(negedge clk_clk);
                    if (!s1_waitrequest) ok = 1'b0;
                end
                chk("full fifo s1_waitrequest held", 64'(ok), 64'd1);
                chk("full fifo no 5th accept", 64'(n_rd_acc - b_acc), 64'd4);
                hold_rdv = 1'b0;
            end
        join
        step(12);
        chk("fifo 5 reads accepted", 64'(n_rd_acc - b_acc), 64'd5);
        chk("fifo 5 reads returned", 64'(n_rdv1 - b_r1), 64'd5);

        // s1 write stalled 5 cycles: m_* stable, s0 stalled, accepted once.
        wait_mode = 1;
        b_mw = n_mwrite_cyc; b_acc = n_wr_acc;
        fork
            m_op(1, 1'b1, 18'h20055, 32'h12345678, 4'h6);
            begin
                ok = 1'b1;
                n = 0;
                do begin
                    @(negedge clk_clk);
                    n++;
                end while (!m_write && n < 10);
                if (!m_write) fail("stalled write never reached m_write");
                for (int i = 0; i < 6; i++) begin
                    if (i > 0) @(negedge clk_clk);
                    if (m_write !== 1'b1 || m_address !== 18'h20055 || m_writedata !== 32'h12345678 ||
                        m_byteenable !== 4'h6 || s0_waitrequest !== 1'b1) ok = 1'b0;
                    if (i == 4) wait_mode = 2;
                end
                chk("stalled write m_* stable", 64'(ok), 64'd1);
            end
        join
        step(2);
        chk("stalled write m_write cycles", 64'(n_mwrite_cyc - b_mw), 64'd6);
        chk("stalled write accepts", 64'(n_wr_acc - b_acc), 64'd1);

        // Random mixed traffic from both masters with random stalls and latency.
        wait_mode = 0; lat_min = 1; lat_max = 4;
        fork
            for (int i = 0; i < 40; i++) begin
                bit w = $urandom % 2;
                m_op(0, w, w ? {1'b0, 17'($urandom)} : 18'($urandom), $urandom, 4'($urandom));
                step($urandom_range(2, 0));
            end
            for (int i = 0; i < 40; i++) begin
                bit w = $urandom % 2;
                m_op(1, w, w ? {1'b1, 17'($urandom)} : 18'($urandom), $urandom, 4'($urandom));
                step($urandom_range(2, 0));
            end
        join
        step(30);
        chk("drain s0 reads", 64'(exp_rd0.size()), 64'd0);
        chk("drain s1 reads", 64'(exp_rd1.size()), 64'd0);
        chk("drain s0 writes", 64'(exp_wr0.size()), 64'd0);
        chk("drain s1 writes", 64'(exp_wr1.size()), 64'd0);

        // Reset during XFER, then a stale response arrives with nothing pending.
        wait_mode = 1;
        drive(0, 1'b1, 1'b0, 18'h20, '0, 4'hF);
        n = 0;
        do begin
            @(negedge clk_clk);
            n++;
        end while (!m_read && n < 10);
        chk("mid-xfer m_read before reset", 64'(m_read), 64'd1);
        #2 reset_reset_n = 1'b0;
        #1;
        chk("reset drops m_read at once", 64'(m_read), 64'd0);
        chk("reset s0_waitrequest", 64'(s0_waitrequest), 64'd1);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        step(2);
        reset_reset_n = 1'b1;
        wait_mode = 2;
        step(4);
        chk("orphan_err before stray rdv", 64'(orphan_err), 64'd0);
        @(negedge clk_clk);
        inject_req++;
        @(negedge clk_clk);
        chk("stray rdv not routed", 64'({s0_readdatavalid, s1_readdatavalid}), 64'd0);
        @(negedge clk_clk);
        chk("orphan_err set", 64'(orphan_err), 64'd1);
        step(3);
        chk("orphan_err sticky", 64'(orphan_err), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
